// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle: decoded instruction in, registered result and stall out.
// master = upstream (decode / testbench), slave = ex_stage.
interface ex_stage_if #(
    parameter int N = 32
);
    logic         valid_in;
    logic [2:0]   op;
    logic [1:0]   func;
    logic [4:0]   rw;
    logic [N-1:0] rda;
    logic [N-1:0] rdb;
    logic [N-1:0] extended;
    logic         stall;
    logic         valid_out;
    logic [N-1:0] result;
    logic [4:0]   rw_out;
    logic [2:0]   op_out;

    modport master (
        output valid_in, op, func, rw, rda, rdb, extended,
        input  stall, valid_out, result, rw_out, op_out
    );

    modport slave (
        input  valid_in, op, func, rw, rda, rdb, extended,
        output stall, valid_out, result, rw_out, op_out
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage of the RSA ASIP: single-cycle add/sub/address ops and iterative
// shift-add multiply / restoring modulo that stall upstream while in flight.
module ex_stage #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        reset,
    ex_stage_if.slave   bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_mod_q, is_mod_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  opa_q, opa_d;
    logic [N-1:0]  opb_q, opb_d;
    logic [4:0]    rw_lat_q, rw_lat_d;
    logic [2:0]    op_lat_q, op_lat_d;
    logic          valid_out_q, valid_out_d;
    logic [N-1:0]  result_q, result_d;
    logic [4:0]    rw_out_q, rw_out_d;
    logic [2:0]    op_out_q, op_out_d;

    logic          alu_form_s;
    logic          multi_s;
    logic [N-1:0]  b_sel_s;
    logic [N-1:0]  single_res_s;
    logic [N-1:0]  mul_acc_s;
    logic [N:0]    rem_sh_s;
    logic [N:0]    rem_diff_s;
    logic          rem_ge_s;
    logic [N-1:0]  rem_next_s;
    logic [N-1:0]  step_acc_s;
    logic [N-1:0]  step_opb_s;

    assign alu_form_s = (bus.op == 3'b000) || (bus.op == 3'b001);
    assign multi_s    = alu_form_s && bus.func[1];
    assign b_sel_s    = (bus.op == 3'b001) ? bus.extended : bus.rdb;

    // Single-cycle result selection
    always_comb begin
        single_res_s = bus.rda + bus.extended;
        if (alu_form_s) begin
            case (bus.func)
                2'b00:   single_res_s = bus.rda + b_sel_s;
                2'b01:   single_res_s = bus.rda - b_sel_s;
                default: single_res_s = bus.rda + bus.extended;
            endcase
        end else begin
            single_res_s = bus.rda + bus.extended;
        end
    end

    // Multiply: opa is the left-shifting multiplicand, opb the right-shifting multiplier.
    assign mul_acc_s  = opb_q[0] ? (acc_q + opa_q) : acc_q;
    // Modulo: opa shifts dividend bits into the partial remainder; opb holds the divisor.
    // A zero divisor always "fits", so the remainder simply becomes the dividend.
    assign rem_sh_s   = {acc_q, opa_q[N-1]};
    assign rem_diff_s = rem_sh_s - {1'b0, opb_q};
    assign rem_ge_s   = (rem_sh_s >= {1'b0, opb_q});
    assign rem_next_s = rem_ge_s ? rem_diff_s[N-1:0] : rem_sh_s[N-1:0];

    assign step_acc_s = is_mod_q ? rem_next_s : mul_acc_s;
    assign step_opb_s = is_mod_q ? opb_q : (opb_q >> 1);

    // Next-state and output register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_mod_d    = is_mod_q;
        acc_d       = acc_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        rw_lat_d    = rw_lat_q;
        op_lat_d    = op_lat_q;
        valid_out_d = 1'b0;
        result_d    = result_q;
        rw_out_d    = rw_out_q;
        op_out_d    = op_out_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.valid_in) begin
                    if (multi_s) begin
                        opa_d    = bus.rda;
                        opb_d    = b_sel_s;
                        acc_d    = '0;
                        cnt_d    = '0;
                        is_mod_d = bus.func[0];
                        rw_lat_d = bus.rw;
                        op_lat_d = bus.op;
                        state_d  = S_BUSY;
                    end else begin
                        result_d    = single_res_s;
                        rw_out_d    = bus.rw;
                        op_out_d    = bus.op;
                        valid_out_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_d = step_acc_s;
                opa_d = opa_q << 1;
                opb_d = step_opb_s;
                if (cnt_q == CW'(N - 1)) begin
                    result_d    = step_acc_s;
                    rw_out_d    = rw_lat_q;
                    op_out_d    = op_lat_q;
                    valid_out_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_mod_q    <= 1'b0;
            acc_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rw_lat_q    <= 5'd0;
            op_lat_q    <= 3'd0;
            valid_out_q <= 1'b0;
            result_q    <= '0;
            rw_out_q    <= 5'd0;
            op_out_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_mod_q    <= is_mod_d;
            acc_q       <= acc_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            rw_lat_q    <= rw_lat_d;
            op_lat_q    <= op_lat_d;
            valid_out_q <= valid_out_d;
            result_q    <= result_d;
            rw_out_q    <= rw_out_d;
            op_out_q    <= op_out_d;
        end
    end

    assign bus.stall     = (state_q == S_BUSY);
    assign bus.valid_out = valid_out_q;
    assign bus.result    = result_q;
    assign bus.rw_out    = rw_out_q;
    assign bus.op_out    = op_out_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: single-cycle ops, multi-cycle mul/mod latency,
// stall hold, DONE-cycle acceptance and reset behaviour.
module tb_ex_stage;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    ex_stage_if #(.N(32)) bus ();

    ex_stage #(.N(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [1:0] f,
                         input logic [31:0] a, input logic [31:0] rb,
                         input logic [31:0] ext, input logic [4:0] r);
        bus.valid_in = v;
        bus.op       = o;
        bus.func     = f;
        bus.rda      = a;
        bus.rdb      = rb;
        bus.extended = ext;
        bus.rw       = r;
    endtask

    // Accept a multi-cycle op, then count stalled cycles and cycles to valid_out.
    task automatic run_multi(input string tag, input logic [2:0] o, input logic [1:0] f,
                             input logic [31:0] a, input logic [31:0] rb,
                             input logic [31:0] ext, input logic [4:0] r,
                             input logic [31:0] exp);
        int n;
        int s;
        n = 0;
        s = 0;
        @(negedge clk);
        drive(1'b1, o, f, a, rb, ext, r);
        @(posedge clk);
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) bus.valid_in = 1'b0;
            if (bus.valid_out === 1'b1) break;
            if (bus.stall === 1'b1) s++;
        end
        chk({tag, "_latency"}, n, 32'd33);
        chk({tag, "_stall_cycles"}, s, 32'd32);
        chk({tag, "_result"}, bus.result, exp);
        chk({tag, "_rw_out"}, {27'd0, bus.rw_out}, {27'd0, r});
        chk({tag, "_op_out"}, {29'd0, bus.op_out}, {29'd0, o});
        @(negedge clk);
        chk({tag, "_valid_drop"}, {31'd0, bus.valid_out}, 32'd0);
        chk({tag, "_result_hold"}, bus.result, exp);
    endtask

    initial begin
        int n;
        int ones;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        drive(1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_rw", {27'd0, bus.rw_out}, 32'd0);
        chk("rst_op", {29'd0, bus.op_out}, 32'd0);

        // Register add 5+7
        drive(1'b1, 3'b000, 2'b00, 32'd5, 32'd7, 32'd0, 5'd3);
        chk("add_stall_pre", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0, 32'd0, 5'd0);
        chk("add_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("add_result", bus.result, 32'd12);
        chk("add_rw", {27'd0, bus.rw_out}, 32'd3);
        chk("add_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        chk("idle_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("idle_hold", bus.result, 32'd12);

        // Immediate sub wraps; rdb must be ignored
        drive(1'b1, 3'b001, 2'b01, 32'd0, 32'd99, 32'd1, 5'd4);
        @(negedge clk);
        chk("subi_result", bus.result, 32'hFFFF_FFFF);
        chk("subi_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("subi_op", {29'd0, bus.op_out}, 32'd1);

        // Address op: rda + extended, func ignored; then two more back-to-back
        drive(1'b1, 3'b101, 2'b10, 32'h0000_0100, 32'd7, 32'h0000_0020, 5'd6);
        @(negedge clk);
        chk("addr_result", bus.result, 32'h0000_0120);
        chk("addr_op", {29'd0, bus.op_out}, 32'd5);
        chk("addr_stall", {31'd0, bus.stall}, 32'd0);
        drive(1'b1, 3'b000, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd7);
        @(negedge clk);
        chk("b2b_add_wrap", bus.result, 32'd0);
        chk("b2b_valid1", {31'd0, bus.valid_out}, 32'd1);
        drive(1'b1, 3'b000, 2'b01, 32'd10, 32'd3, 32'd0, 5'd8);
        @(negedge clk);
        chk("b2b_sub", bus.result, 32'd7);
        chk("b2b_valid2", {31'd0, bus.valid_out}, 32'd1);
        bus.valid_in = 1'b0;

        run_multi("mul", 3'b000, 2'b10, 32'h0001_0001, 32'h0001_0001, 32'd0, 5'd10, 32'h0002_0001);
        run_multi("muli", 3'b001, 2'b10, 32'hFFFF_FFFF, 32'd3, 32'd2, 5'd11, 32'hFFFF_FFFE);
        run_multi("mod", 3'b000, 2'b11, 32'd100, 32'd7, 32'd0, 5'd12, 32'd2);
        run_multi("mod0", 3'b000, 2'b11, 32'd123, 32'd0, 32'd0, 5'd13, 32'd123);
        run_multi("modi", 3'b001, 2'b11, 32'hFFFF_FFFF, 32'd5, 32'h10, 5'd14, 32'd15);

        // Mul followed by an add held on the inputs under stall
        @(negedge clk);
        drive(1'b1, 3'b000, 2'b10, 32'h0001_0001, 32'h0001_0001, 32'd0, 5'd8);
        @(posedge clk);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) drive(1'b1, 3'b000, 2'b00, 32'd5, 32'd7, 32'd0, 5'd9);
            if (bus.valid_out === 1'b1) break;
        end
        chk("hold_mul_latency", n, 32'd33);
        chk("hold_mul_result", bus.result, 32'h0002_0001);
        chk("hold_mul_rw", {27'd0, bus.rw_out}, 32'd8);
        chk("hold_done_stall", {31'd0, bus.stall}, 32'd0);
        @(negedge clk);
        bus.valid_in = 1'b0;
        chk("hold_add_valid", {31'd0, bus.valid_out}, 32'd1);
        chk("hold_add_result", bus.result, 32'd12);
        chk("hold_add_rw", {27'd0, bus.rw_out}, 32'd9);
        @(negedge clk);
        chk("hold_after_valid", {31'd0, bus.valid_out}, 32'd0);

        // Reset ten cycles into a mod aborts it
        drive(1'b1, 3'b000, 2'b11, 32'd100, 32'd7, 32'd0, 5'd15);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
        chk("midop_stall", {31'd0, bus.stall}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_stall", {31'd0, bus.stall}, 32'd0);
        chk("abort_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_rw", {27'd0, bus.rw_out}, 32'd0);
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0 || bus.stall !== 1'b0) ones++;
        end
        chk("abort_no_late_valid", ones, 32'd0);

        // Reset wins over valid_in on the same edge
        drive(1'b1, 3'b000, 2'b00, 32'd5, 32'd7, 32'd0, 5'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.valid_in = 1'b0;
        chk("rst_prio_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_prio_result", bus.result, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RSA-decryption ASIP pipeline, directly downstream of the instruction decode stage. Consumes decoded opcode, function, destination register and operand data. Produces a registered result for the memory/write-back path. Add and subtract complete in one cycle. Unsigned multiply and modulo, the core of modular exponentiation, run as iterative multi-cycle operations that stall the pipeline.

## Interface
- N, 32, datapath width in bits; also the iteration count for multi-cycle ops.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  decoded instruction present on the inputs.
- op  in  3  operation code from decode.
- func  in  2  ALU function from decode.
- rw  in  5  destination register from decode.
- rda  in  N  data of source register a.
- rdb  in  N  data of source register b.
- extended  in  N  zero-extended constant from decode.
- stall  out  1  upstream must hold its outputs and valid_in.
- valid_out  out  1  result, rw_out and op_out are valid this cycle.
- result  out  N  operation result.
- rw_out  out  5  destination register of the result.
- op_out  out  3  operation code of the result.

## Operation
Operand selection:
- a = rda.
- b = rdb when op = 3'b000 (register form).
- b = extended when op = 3'b001 (immediate form).

For op 000 and 001, func selects the operation:
- 00: add, a+b mod 2^N, single-cycle.
- 01: sub, a-b mod 2^N, single-cycle.
- 10: mul, low N bits of unsigned a*b, multi-cycle, shift-add, one bit per cycle.
- 11: mod, unsigned a mod b, multi-cycle, restoring division, one bit per cycle. When b = 0, result = a.

Any other op (010-111) is an address/pass-through op: result = rda + extended, single-cycle, func ignored.

FSM states:
- IDLE: no operation in flight.
- BUSY: multi-cycle operation iterating.
- DONE: multi-cycle result presented.

Transitions:
- IDLE or DONE with valid_in=1 and a single-cycle op: register result, rw and op; assert valid_out next cycle; state becomes IDLE.
- IDLE or DONE with valid_in=1 and a multi-cycle op: latch a, b, rw and op; clear iteration counter; go to BUSY.
- IDLE or DONE with valid_in=0: go to IDLE; valid_out=0 next cycle.
- BUSY: one iteration per edge; counter increments. After iteration N-1, register result and go to DONE.
- DONE: valid_out=1 for exactly that one cycle. DONE accepts a new instruction exactly like IDLE.

Handshake rules:
- stall = (state == BUSY), combinational from state.
- While stall=1, valid_in and all inputs are ignored. Upstream holds them.
- The held instruction is accepted on the first edge with stall=0.

## Timing
- Reset: state IDLE, counter 0, and outputs stall, valid_out, result, rw_out, op_out all 0.
- Single-cycle op accepted at edge k: valid_out=1 in the cycle after edge k.
- Multi-cycle op accepted at edge k:
  - stall=1 for the N cycles after edges k .. k+N-1.
  - valid_out=1 in the cycle after edge k+N.
  - Total latency N+1 edges.
- result, rw_out and op_out hold their last value when valid_out=0.
- Back-to-back single-cycle ops sustain one result per cycle.
- A single-cycle op may be accepted in DONE, giving valid_out on two consecutive cycles.
- Reset mid-BUSY aborts the operation; no valid_out is produced for it.
- Reset has priority over valid_in on the same edge.
- Counter is ceil(log2 N) bits and never wraps while in BUSY.

## Test plan
- Add: op=000, func=00, rda=5, rdb=7, rw=3 → next cycle valid_out=1, result=12, rw_out=3, stall never asserted.
- Immediate sub wrap: op=001, func=01, rda=0, extended=1 → result=0xFFFFFFFF after 1 edge.
- Mul: op=000, func=10, rda=rdb=0x00010001 → stall high 32 cycles, then valid_out=1 with result=0x00020001 (33 edges after acceptance).
- Mod and divide-by-zero: rda=100, rdb=7 → result=2. Then rda=123, rdb=0 → result=123. Both with latency 33.
- Stall hold: mul immediately followed by add (5+7) held on inputs under stall → add accepted in DONE cycle, valid_out high two consecutive cycles, results mul then 12.
- Reset mid-op: reset asserted 10 cycles into a mod → next cycle stall=0, valid_out=0, result=0, state IDLE; no late valid_out afterwards.
